l1_mem_arbiter: RTL and testbench

- Shares one physical memory port between the split L1 instruction cache and L1 data cache.
- Sits between both caches' pmem-side interfaces and the top-level pmem_* pins.
- Owns one outstanding line transaction at a time, with round-robin tie-break.
- Latches the winning request so pmem sees stable command, address and data until pmem_resp.

---
 rtl/l1_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_l1_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// Arbitrates one shared physical memory port between the L1 I-cache and D-cache.
// One line transaction is in flight at a time; ties alternate between the two caches.
//
// state   | meaning
// IDLE    | no transaction; arbitrate incoming requests
// GRANT_I | I-cache fill in flight, waiting for pmem_resp
// GRANT_D | D-cache fill/writeback in flight, waiting for pmem_resp
// RELEASE | one dead cycle so the finished requester can drop its request
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0]  icache_pmem_address,
    output logic [BLOCK_WIDTH-1:0] icache_pmem_rdata,
    output logic                   icache_pmem_resp,
    input  logic                   dcache_pmem_read,
    input  logic                   dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0]  dcache_pmem_address,
    input  logic [BLOCK_WIDTH-1:0] dcache_pmem_wdata,
    output logic [BLOCK_WIDTH-1:0] dcache_pmem_rdata,
    output logic                   dcache_pmem_resp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [ADDR_WIDTH-1:0]  pmem_address,
    output logic [BLOCK_WIDTH-1:0] pmem_wdata,
    input  logic [BLOCK_WIDTH-1:0] pmem_rdata,
    input  logic                   pmem_resp,
    output logic [1:0]             grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_grant;   // 0: I-cache won last, 1: D-cache won last
    logic                   r_cmd_read;
    logic                   r_cmd_write;
    logic [ADDR_WIDTH-1:0]  r_addr_q;
    logic [BLOCK_WIDTH-1:0] r_wdata_q;

    logic w_req_i;
    logic w_req_d;
    logic w_pick_i;
    logic w_pick_d;
    logic w_busy;

    assign w_req_i  = icache_pmem_read;
    assign w_req_d  = dcache_pmem_read | dcache_pmem_write;
    assign w_pick_i = w_req_i & (~w_req_d | r_last_grant);
    assign w_pick_d = w_req_d & ~w_pick_i;
    assign w_busy   = (r_state == GRANT_I) || (r_state == GRANT_D);

    always_comb begin
        w_next_state      = r_state;
        icache_pmem_resp  = 1'b0;
        dcache_pmem_resp  = 1'b0;
        icache_pmem_rdata = '0;
        dcache_pmem_rdata = '0;
        grant             = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_pick_i)
                    w_next_state = GRANT_I;
                else if (w_pick_d)
                    w_next_state = GRANT_D;
            end
            GRANT_I: begin
                grant             = 2'b01;
                icache_pmem_resp  = pmem_resp;
                icache_pmem_rdata = pmem_rdata;
                if (pmem_resp)
                    w_next_state = RELEASE;
            end
            GRANT_D: begin
                grant             = 2'b10;
                dcache_pmem_resp  = pmem_resp;
                dcache_pmem_rdata = pmem_rdata;
                if (pmem_resp)
                    w_next_state = RELEASE;
            end
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Command registers are cleared on resp, so they read as zero outside a grant.
    assign pmem_read    = r_cmd_read;
    assign pmem_write   = r_cmd_write;
    assign pmem_address = r_addr_q;
    assign pmem_wdata   = r_wdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cmd_read   <= 1'b0;
            r_cmd_write  <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) begin
                if (w_pick_i) begin
                    r_cmd_read  <= 1'b1;
                    r_cmd_write <= 1'b0;
                    r_addr_q    <= icache_pmem_address;
                    r_wdata_q   <= '0;
                end else if (w_pick_d) begin
                    // read+write together is illegal; the writeback wins
                    r_cmd_read  <= dcache_pmem_read & ~dcache_pmem_write;
                    r_cmd_write <= dcache_pmem_write;
                    r_addr_q    <= dcache_pmem_address;
                    r_wdata_q   <= dcache_pmem_wdata;
                end
            end else if (w_busy && pmem_resp) begin
                r_last_grant <= (r_state == GRANT_D);
                r_cmd_read   <= 1'b0;
                r_cmd_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: vector table, directed corner cases,
// and random traffic compared against a transaction-level reference model.
module tb_l1_mem_arbiter;

    localparam int AW = 16;
    localparam int BW = 128;

    logic          clk;
    logic          reset_n;
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic [BW-1:0] i_rdata;
    logic          i_resp;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [BW-1:0] d_wdata;
    logic [BW-1:0] d_rdata;
    logic          d_resp;
    logic          p_rd;
    logic          p_wr;
    logic [AW-1:0] p_addr;
    logic [BW-1:0] p_wdata;
    logic [BW-1:0] p_rdata;
    logic          p_resp;
    logic [1:0]    grant;

    l1_mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_pmem_read(i_rd), .icache_pmem_address(i_addr),
        .icache_pmem_rdata(i_rdata), .icache_pmem_resp(i_resp),
        .dcache_pmem_read(d_rd), .dcache_pmem_write(d_wr),
        .dcache_pmem_address(d_addr), .dcache_pmem_wdata(d_wdata),
        .dcache_pmem_rdata(d_rdata), .dcache_pmem_resp(d_resp),
        .pmem_read(p_rd), .pmem_write(p_wr), .pmem_address(p_addr),
        .pmem_wdata(p_wdata), .pmem_rdata(p_rdata), .pmem_resp(p_resp),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 I, 2 D), whether the
    // post-transaction cooldown is pending, and the latched command.
    bit            m_valid = 0;
    int            m_owner;
    bit            m_cool;
    bit            m_last_d;
    bit            m_rd, m_wr;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata;

    task automatic model_check();
        if (!m_valid) return;
        chk("m_pmem_read",  p_rd,  m_rd);
        chk("m_pmem_write", p_wr,  m_wr);
        if (m_rd || m_wr) chk("m_pmem_address", p_addr, m_addr);
        if (m_wr) chk("m_pmem_wdata", p_wdata, m_wdata);
        chk("m_grant", grant, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
        chk("m_icache_resp", i_resp, (m_owner == 1) && p_resp);
        chk("m_dcache_resp", d_resp, (m_owner == 2) && p_resp);
        chk("m_icache_rdata", i_rdata, (m_owner == 1) ? p_rdata : '0);
        chk("m_dcache_rdata", d_rdata, (m_owner == 2) ? p_rdata : '0);
    endtask

    task automatic model_step();
        bit want_i, want_d;
        if (!reset_n) begin
            m_valid = 1; m_owner = 0; m_cool = 0; m_last_d = 1;
            m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        end else if (m_owner != 0) begin
            if (p_resp) begin
                m_last_d = (m_owner == 2);
                m_owner  = 0; m_cool = 1; m_rd = 0; m_wr = 0;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else begin
            want_i = i_rd;
            want_d = d_rd || d_wr;
            if (want_i && want_d) begin
                want_i = m_last_d;
                want_d = !m_last_d;
            end
            if (want_i) begin
                m_owner = 1; m_rd = 1; m_wr = 0; m_addr = i_addr; m_wdata = '0;
            end else if (want_d) begin
                m_owner = 2; m_wr = d_wr; m_rd = d_rd && !d_wr;
                m_addr = d_addr; m_wdata = d_wdata;
            end
        end
    endtask

    // Caller sets inputs shortly after a posedge; this checks at the negedge,
    // advances the model and returns just after the next posedge.
    task automatic step_from_negedge();
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        step_from_negedge();
    endtask

    task automatic idle_inputs();
        i_rd = 0; i_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        p_resp = 0; p_rdata = '0;
    endtask

    typedef struct {
        bit            rst_n, ir, dr, dw, presp;
        logic [AW-1:0] ia, da;
        logic [BW-1:0] dwd, prd;
        bit            e_pr, e_pw, e_ir, e_dr;
        logic [AW-1:0] e_pa;
        logic [BW-1:0] e_wd;
        logic [1:0]    e_gr;
    } vec_t;

    function automatic vec_t mk(bit rst_n, bit ir, logic [AW-1:0] ia, bit dr, bit dw,
                                logic [AW-1:0] da, logic [BW-1:0] dwd, bit presp,
                                logic [BW-1:0] prd, bit e_pr, bit e_pw, logic [AW-1:0] e_pa,
                                logic [BW-1:0] e_wd, logic [1:0] e_gr, bit e_ir, bit e_dr);
        vec_t v;
        v.rst_n = rst_n; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.dwd = dwd; v.presp = presp; v.prd = prd; v.e_pr = e_pr; v.e_pw = e_pw;
        v.e_pa = e_pa; v.e_wd = e_wd; v.e_gr = e_gr; v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        logic [BW-1:0] a5, dd, ff;
        int n;
        a5 = {16{8'hA5}};
        dd = 128'h0123456789ABCDEF0123456789ABCDEF;
        ff = '1;
        //           rst ir ia     dr dw da       dwd presp prd  pr pw pa       wd  gr ir dr
        tbl[0]  = mk(1, 1, 'h0040, 0, 0, 'h0000, '0, 0, '0,  0, 0, 'h0000, '0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 'h0040, 0, 0, 'h0000, '0, 0, '0,  1, 0, 'h0040, '0, 1, 0, 0);
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(1, 1, 'h0040, 0, 0, 'h0000, '0, 1, a5,  1, 0, 'h0040, '0, 1, 1, 0);
        tbl[5]  = mk(1, 0, 'h0000, 0, 0, 'h0000, '0, 0, '0,  0, 0, 'h0000, '0, 0, 0, 0);
        tbl[6]  = tbl[5];
        tbl[7]  = mk(1, 0, 'h0000, 0, 1, 'h1230, dd, 0, '0, 0, 0, 'h0000, '0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 'h0000, 0, 1, 'hFFFF, ff, 0, '0, 0, 1, 'h1230, dd, 2, 0, 0);
        tbl[9]  = tbl[8];
        tbl[10] = mk(1, 0, 'h0000, 0, 1, 'hFFFF, ff, 1, a5, 0, 1, 'h1230, dd, 2, 0, 1);
        tbl[11] = tbl[5];
        tbl[12] = tbl[5];
        tbl[13] = mk(1, 0, 'h0000, 1, 1, 'h2000, '0, 0, '0,  0, 0, 'h0000, '0, 0, 0, 0);
        tbl[14] = mk(1, 0, 'h0000, 1, 1, 'h2000, '0, 0, '0,  0, 1, 'h2000, '0, 2, 0, 0);
        tbl[15] = mk(1, 0, 'h0000, 1, 1, 'h2000, '0, 1, '0,  0, 1, 'h2000, '0, 2, 0, 1);
        tbl[16] = tbl[5];

        idle_inputs();
        reset_n = 0;
        @(posedge clk); #1;
        cyc();
        reset_n = 1;
        chk("reset_pmem_read", p_rd, 1'b0);
        chk("reset_pmem_write", p_wr, 1'b0);
        chk("reset_grant", grant, 2'b00);
        chk("reset_pmem_address", p_addr, '0);

        for (int k = 0; k < 17; k++) begin
            reset_n = tbl[k].rst_n; i_rd = tbl[k].ir; i_addr = tbl[k].ia;
            d_rd = tbl[k].dr; d_wr = tbl[k].dw; d_addr = tbl[k].da; d_wdata = tbl[k].dwd;
            p_resp = tbl[k].presp; p_rdata = tbl[k].prd;
            @(negedge clk);
            chk($sformatf("tbl%0d_pmem_read", k), p_rd, tbl[k].e_pr);
            chk($sformatf("tbl%0d_pmem_write", k), p_wr, tbl[k].e_pw);
            chk($sformatf("tbl%0d_grant", k), grant, tbl[k].e_gr);
            chk($sformatf("tbl%0d_icache_resp", k), i_resp, tbl[k].e_ir);
            chk($sformatf("tbl%0d_dcache_resp", k), d_resp, tbl[k].e_dr);
            if (tbl[k].e_pr || tbl[k].e_pw)
                chk($sformatf("tbl%0d_pmem_address", k), p_addr, tbl[k].e_pa);
            if (tbl[k].e_pw)
                chk($sformatf("tbl%0d_pmem_wdata", k), p_wdata, tbl[k].e_wd);
            if (tbl[k].e_ir)
                chk($sformatf("tbl%0d_icache_rdata", k), i_rdata, tbl[k].prd);
            step_from_negedge();
        end

        // Both caches request continuously after reset: strict alternation from I.
        idle_inputs();
        reset_n = 0;
        cyc();
        reset_n = 1;
        i_rd = 1; i_addr = 'h0100; d_rd = 1; d_addr = 'h0200;
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (grant == 2'b00 && n < 10) begin
                cyc();
                n++;
            end
            chk($sformatf("rr%0d_timeout", t), (n < 10), 1'b1);
            chk($sformatf("rr%0d_grant", t), grant, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d_pmem_address", t), p_addr, (t % 2 == 0) ? 16'h0100 : 16'h0200);
            if (t > 0) chk($sformatf("rr%0d_gap", t), n, 2);
            cyc();
            p_resp = 1; p_rdata = {4{$urandom}};
            cyc();
            p_resp = 0;
        end

        // Reset in the second cycle of a D-cache read.
        idle_inputs();
        cyc();
        cyc();
        d_rd = 1; d_addr = 'h3000;
        cyc();
        cyc();
        chk("rst_mid_pmem_read_before", p_rd, 1'b1);
        reset_n = 0;
        cyc();
        reset_n = 1; d_rd = 0;
        chk("rst_mid_pmem_read", p_rd, 1'b0);
        chk("rst_mid_grant", grant, 2'b00);
        p_resp = 1;
        #1;
        chk("rst_mid_late_resp", d_resp, 1'b0);
        cyc();
        p_resp = 0;

        // Random traffic against the reference model.
        for (int r = 0; r < 600; r++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            i_rd    = ($urandom_range(0, 2) != 0);
            i_addr  = AW'($urandom);
            d_rd    = ($urandom_range(0, 2) == 0);
            d_wr    = ($urandom_range(0, 2) == 0);
            d_addr  = AW'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
            p_resp  = ($urandom_range(0, 2) == 0);
            p_rdata = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
